// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - packet input / FIFO control strobes between router blocks and router_fsm
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, write_enb_reg, rst_int_reg
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
        output full_state, write_enb_reg, rst_int_reg
    );
endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - Moore packet-reception controller for the 1x3 router
module router_fsm #(
    parameter int NUM_DEST = 3
) (
    input  logic          clock,
    input  logic          reset,
    router_fsm_if.slave   bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] addr_q;
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       addr_valid;
    logic       empty_in;
    logic       empty_sel;
    logic       soft_sel;
    logic       header_ok;

    // Padded to 4 entries so the 2-bit address never selects out of range.
    assign empty_vec  = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_vec   = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign addr_valid = ({1'b0, bus.data_in} < 3'(NUM_DEST));
    assign empty_in   = empty_vec[bus.data_in];
    assign empty_sel  = empty_vec[addr_q];
    assign soft_sel   = soft_vec[addr_q];
    assign header_ok  = (state_q == DECODE_ADDRESS) && bus.pkt_valid && addr_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (header_ok) begin
                addr_q <= bus.data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (header_ok) begin
                    state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_sel) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the addressed FIFO abandons the packet from any busy state.
        if ((state_q != DECODE_ADDRESS) && soft_sel) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_comb begin
        bus.detect_add    = (state_q == DECODE_ADDRESS);
        bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
        bus.ld_state      = (state_q == LOAD_DATA);
        bus.laf_state     = (state_q == LOAD_AFTER_FULL);
        bus.full_state    = (state_q == FIFO_FULL_STATE);
        bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                            (state_q == LOAD_PARITY);
        bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed self-checking bench for router_fsm
module tb_router_fsm;

    // Output vector: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
    localparam logic [7:0] O_DEC = 8'b0100_0000;
    localparam logic [7:0] O_LFD = 8'b1010_0000;
    localparam logic [7:0] O_LD  = 8'b0001_0010;
    localparam logic [7:0] O_FUL = 8'b1000_0100;
    localparam logic [7:0] O_LAF = 8'b1000_1010;
    localparam logic [7:0] O_LP  = 8'b1000_0010;
    localparam logic [7:0] O_CPE = 8'b1000_0001;
    localparam logic [7:0] O_WTE = 8'b1000_0000;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   we_cnt;

    router_fsm_if bus_if ();

    router_fsm #(.NUM_DEST(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {bus_if.busy, bus_if.detect_add, bus_if.lfd_state, bus_if.ld_state,
                bus_if.laf_state, bus_if.full_state, bus_if.write_enb_reg, bus_if.rst_int_reg};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clock);
        #1;
        we_cnt += int'(bus_if.write_enb_reg);
        check(tag, 32'(outs()), 32'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        reset    = 1'b1;
        bus_if.pkt_valid     = 1'b0;
        bus_if.data_in       = 2'd0;
        bus_if.fifo_full     = 1'b0;
        bus_if.fifo_empty_0  = 1'b0;
        bus_if.fifo_empty_1  = 1'b0;
        bus_if.fifo_empty_2  = 1'b0;
        bus_if.soft_reset_0  = 1'b0;
        bus_if.soft_reset_1  = 1'b0;
        bus_if.soft_reset_2  = 1'b0;
        bus_if.parity_done   = 1'b0;
        bus_if.low_pkt_valid = 1'b0;
        #2;
        check("reset_outs", 32'(outs()), 32'(O_DEC));
        check("reset_addr", 32'(dut.addr_q), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Packet to FIFO 1: header, 4 payload cycles, parity
        bus_if.pkt_valid    = 1'b1;
        bus_if.data_in      = 2'd1;
        bus_if.fifo_empty_1 = 1'b1;
        step("t1_lfd", O_LFD);
        check("t1_addr", 32'(dut.addr_q), 32'd1);
        we_cnt = 0;
        step("t1_ld", O_LD);
        for (int i = 0; i < 3; i++) step("t2_ld_hold", O_LD);
        bus_if.pkt_valid = 1'b0;
        step("t2_lp", O_LP);
        step("t2_cpe", O_CPE);
        step("t2_dec", O_DEC);
        check("t2_we_cycles", 32'(we_cnt), 32'd5);

        // Packet to FIFO 2 stalls until the FIFO drains
        bus_if.pkt_valid    = 1'b1;
        bus_if.data_in      = 2'd2;
        bus_if.fifo_empty_2 = 1'b0;
        for (int i = 0; i < 6; i++) step("t3_wte", O_WTE);
        check("t3_addr", 32'(dut.addr_q), 32'd2);
        bus_if.fifo_empty_2 = 1'b1;
        step("t3_lfd", O_LFD);
        step("t3_ld", O_LD);

        // Full for 3 cycles, resume via LOAD_AFTER_FULL back to LOAD_DATA
        bus_if.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("t4_full", O_FUL);
        bus_if.fifo_full = 1'b0;
        step("t4_laf", O_LAF);
        step("t4_laf_to_ld", O_LD);

        // Full and pkt_valid falling together: full wins, then low_pkt_valid path
        bus_if.fifo_full = 1'b1;
        bus_if.pkt_valid = 1'b0;
        step("t4_full_wins", O_FUL);
        bus_if.fifo_full = 1'b0;
        step("t4_laf2", O_LAF);
        bus_if.low_pkt_valid = 1'b1;
        step("t4_laf_to_lp", O_LP);
        bus_if.low_pkt_valid = 1'b0;
        step("t4_cpe", O_CPE);
        step("t4_dec", O_DEC);

        // Packet to FIFO 0, full then parity_done returns to decode
        bus_if.pkt_valid    = 1'b1;
        bus_if.data_in      = 2'd0;
        bus_if.fifo_empty_0 = 1'b1;
        step("t4_lfd0", O_LFD);
        step("t4_ld0", O_LD);
        bus_if.fifo_full = 1'b1;
        step("t4_full0", O_FUL);
        bus_if.fifo_full = 1'b0;
        step("t4_laf0", O_LAF);
        bus_if.parity_done = 1'b1;
        bus_if.pkt_valid   = 1'b0;
        step("t4_laf_to_dec", O_DEC);
        bus_if.parity_done = 1'b0;

        // Soft reset: only the addressed FIFO's timeout matters
        bus_if.pkt_valid    = 1'b1;
        bus_if.fifo_empty_0 = 1'b0;
        step("t5_wte", O_WTE);
        bus_if.pkt_valid    = 1'b0;
        bus_if.soft_reset_1 = 1'b1;
        step("t5_soft_other", O_WTE);
        bus_if.soft_reset_1 = 1'b0;
        bus_if.soft_reset_0 = 1'b1;
        step("t5_soft_sel", O_DEC);
        bus_if.soft_reset_0 = 1'b0;
        check("t5_addr_kept", 32'(dut.addr_q), 32'd0);

        // Invalid address is ignored
        bus_if.pkt_valid = 1'b1;
        bus_if.data_in   = 2'd3;
        step("t6_invalid", O_DEC);
        step("t6_invalid2", O_DEC);
        check("t6_addr", 32'(dut.addr_q), 32'd0);

        // Asynchronous reset mid-packet
        bus_if.data_in = 2'd1;
        step("t6_lfd", O_LFD);
        step("t6_ld", O_LD);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_outs", 32'(outs()), 32'(O_DEC));
        check("t6_async_addr", 32'(dut.addr_q), 32'd0);
        bus_if.pkt_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("t6_after_reset", O_DEC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
